// File: rtl/pads_bus_dir_ctrl.sv
// Bidirectional data pad ring with a direction controller: sequences OE/IE with
// hi-Z turnaround, registers transmit data, and resynchronises captured receive data.

module HIO18_GF28SLP_IOPAD (
  inout  wire  PAD,
  input  logic DATA_OUT,
  input  logic OE,
  input  logic IE,
  input  logic OE18,
  output logic DATA_IN
);
  // OE18 selects the pad supply mode only; it has no logical effect here
  logic unused_oe18;
  assign unused_oe18 = OE18;

  assign PAD     = OE ? DATA_OUT : 1'bz;
  assign DATA_IN = IE ? PAD : 1'b0;
endmodule

module pads_bus_dir_ctrl #(
  parameter int N_PADS   = 16,
  parameter int TURN_CYC = 2,
  parameter int RX_SYNC  = 1,
  parameter int PRIO_RX  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              oe18_tie,
  input  logic [N_PADS-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic              rx_req,
  output logic [N_PADS-1:0] rx_data,
  output logic              rx_valid,
  output logic [1:0]        bus_state,
  inout  wire  [N_PADS-1:0] B_BUS_DATA
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TX   = 2'd1,
    TURN = 2'd2,
    RX   = 2'd3
  } state_t;

  localparam bit RX_FIRST = (PRIO_RX != 0);
  localparam logic [3:0] TURN_LOAD = 4'(TURN_CYC);

  state_t            state, state_nxt;
  logic              oe, oe_nxt;
  logic              ie, ie_nxt;
  logic              run;
  logic [3:0]        cnt, cnt_nxt;
  logic [N_PADS-1:0] drv;
  logic [N_PADS-1:0] pad_in;
  logic              tx_acc;

  always_comb begin
    state_nxt = state;
    oe_nxt    = 1'b0;
    ie_nxt    = 1'b0;
    cnt_nxt   = cnt;
    tx_ready  = 1'b0;
    case (state)
      IDLE: begin
        // a losing TX request is held off by withholding tx_ready
        tx_ready = run & ~(RX_FIRST & rx_req);
        if (tx_ready && tx_valid) begin
          state_nxt = TX;
          oe_nxt    = 1'b1;
        end else if (run && rx_req) begin
          state_nxt = RX;
          ie_nxt    = 1'b1;
        end
      end
      TX: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          oe_nxt = 1'b1;
        end else begin
          state_nxt = TURN;
          cnt_nxt   = TURN_LOAD;
        end
      end
      TURN: begin
        if (cnt <= 4'd1) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RX: begin
        if (rx_req) begin
          ie_nxt = 1'b1;
        end else begin
          state_nxt = TURN;
          cnt_nxt   = TURN_LOAD;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign tx_acc    = tx_ready & tx_valid;
  assign bus_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      oe    <= 1'b0;
      ie    <= 1'b0;
      cnt   <= 4'd0;
      run   <= 1'b0;
      drv   <= '0;
    end else begin
      state <= state_nxt;
      oe    <= oe_nxt;
      ie    <= ie_nxt;
      cnt   <= cnt_nxt;
      run   <= 1'b1;
      if (tx_acc) drv <= tx_data;
    end
  end

  for (genvar i = 0; i < N_PADS; i++) begin : g_pad
    HIO18_GF28SLP_IOPAD u_pad (
      .PAD      (B_BUS_DATA[i]),
      .DATA_OUT (drv[i]),
      .OE       (oe),
      .IE       (ie),
      .OE18     (oe18_tie),
      .DATA_IN  (pad_in[i])
    );
  end

  logic [N_PADS-1:0] data_p0, data_p1, data_p2;
  logic              vld_p0, vld_p1, vld_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p0 <= '0;
      data_p1 <= '0;
      data_p2 <= '0;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
    end else begin
      // p0: capture flop, loads only while the pads are input-enabled
      vld_p0 <= ie;
      if (ie) data_p0 <= pad_in;
      // p1/p2: resync stages; data holds when no word is moving
      vld_p1 <= vld_p0;
      if (vld_p0) data_p1 <= data_p0;
      vld_p2 <= vld_p1;
      if (vld_p1) data_p2 <= data_p1;
    end
  end

  assign rx_valid = (RX_SYNC == 0) ? vld_p0  : (RX_SYNC == 1) ? vld_p1  : vld_p2;
  assign rx_data  = (RX_SYNC == 0) ? data_p0 : (RX_SYNC == 1) ? data_p1 : data_p2;

endmodule

// File: tb/tb_pads_bus_dir_ctrl.sv
// Scoreboard bench for pads_bus_dir_ctrl: a default 16-pad instance and an
// 8-pad instance with RX priority, 5 turnaround cycles and no resync stage.

module tb_pads_bus_dir_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic oe18_tie;

  logic [15:0] tx_data_a, rx_data_a, drv_a;
  logic        tx_valid_a, tx_ready_a, rx_req_a, rx_valid_a, en_a;
  logic [1:0]  state_a;
  wire  [15:0] bus_a;

  logic [7:0]  tx_data_b, rx_data_b, drv_b;
  logic        tx_valid_b, tx_ready_b, rx_req_b, rx_valid_b, en_b;
  logic [1:0]  state_b;
  wire  [7:0]  bus_b;

  assign bus_a = en_a ? drv_a : 'z;
  assign bus_b = en_b ? drv_b : 'z;

  pads_bus_dir_ctrl #(.N_PADS(16), .TURN_CYC(2), .RX_SYNC(1), .PRIO_RX(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .oe18_tie(oe18_tie),
    .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
    .rx_req(rx_req_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
    .bus_state(state_a), .B_BUS_DATA(bus_a)
  );

  pads_bus_dir_ctrl #(.N_PADS(8), .TURN_CYC(5), .RX_SYNC(0), .PRIO_RX(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .oe18_tie(oe18_tie),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .rx_req(rx_req_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
    .bus_state(state_b), .B_BUS_DATA(bus_b)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] exp_tx_a[$];
  logic [15:0] exp_rx_a[$];
  logic [7:0]  exp_tx_b[$];
  logic [7:0]  exp_rx_b[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard whenever a DUT drives the bus or strobes rx_valid,
  // and checks OE/IE exclusivity and the bus-free gap between directions.
  initial begin
    int cyc = 0;
    int last_oe_a = -1000, last_ie_a = -1000, last_oe_b = -1000, last_ie_b = -1000;
    logic oe_prev_a = 1'b0, ie_prev_a = 1'b0, oe_prev_b = 1'b0, ie_prev_b = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (dut_a.oe | dut_a.ie) chk("excl_a", 32'(dut_a.oe & dut_a.ie), 32'd0);
        if (dut_a.oe && !oe_prev_a) chk("gap_ie_oe_a", 32'(cyc - last_ie_a > 3), 32'd1);
        if (dut_a.ie && !ie_prev_a) chk("gap_oe_ie_a", 32'(cyc - last_oe_a > 3), 32'd1);
        if (dut_a.oe) begin
          if (exp_tx_a.size() == 0) chk("tx_a_extra", 32'(bus_a), 32'hFFFF_FFFF);
          else chk("tx_a", 32'(bus_a), 32'(exp_tx_a.pop_front()));
        end
        if (rx_valid_a) begin
          if (exp_rx_a.size() == 0) chk("rx_a_extra", 32'(rx_data_a), 32'hFFFF_FFFF);
          else chk("rx_a", 32'(rx_data_a), 32'(exp_rx_a.pop_front()));
        end
        if (dut_b.oe | dut_b.ie) chk("excl_b", 32'(dut_b.oe & dut_b.ie), 32'd0);
        if (dut_b.oe && !oe_prev_b) chk("gap_ie_oe_b", 32'(cyc - last_ie_b > 6), 32'd1);
        if (dut_b.ie && !ie_prev_b) chk("gap_oe_ie_b", 32'(cyc - last_oe_b > 6), 32'd1);
        if (dut_b.oe) begin
          if (exp_tx_b.size() == 0) chk("tx_b_extra", 32'(bus_b), 32'hFFFF_FFFF);
          else chk("tx_b", 32'(bus_b), 32'(exp_tx_b.pop_front()));
        end
        if (rx_valid_b) begin
          if (exp_rx_b.size() == 0) chk("rx_b_extra", 32'(rx_data_b), 32'hFFFF_FFFF);
          else chk("rx_b", 32'(rx_data_b), 32'(exp_rx_b.pop_front()));
        end
      end
      if (dut_a.oe) last_oe_a = cyc;
      if (dut_a.ie) last_ie_a = cyc;
      if (dut_b.oe) last_oe_b = cyc;
      if (dut_b.ie) last_ie_b = cyc;
      oe_prev_a = dut_a.oe;
      ie_prev_a = dut_a.ie;
      oe_prev_b = dut_b.oe;
      ie_prev_b = dut_b.ie;
    end
  end

  initial begin
    rst_n = 1'b0;
    oe18_tie = 1'b0;
    tx_data_a = '0; tx_valid_a = 1'b0; rx_req_a = 1'b0; en_a = 1'b0; drv_a = '0;
    tx_data_b = '0; tx_valid_b = 1'b0; rx_req_b = 1'b0; en_b = 1'b0; drv_b = '0;

    // reset state
    repeat (2) tick;
    chk("rst_state_a", 32'(state_a), 32'd0);
    chk("rst_ready_a", 32'(tx_ready_a), 32'd0);
    chk("rst_rxv_a", 32'(rx_valid_a), 32'd0);
    chk("rst_rxd_a", 32'(rx_data_a), 32'd0);
    chk("rst_oe_a", 32'(dut_a.oe), 32'd0);
    chk("rst_ie_a", 32'(dut_a.ie), 32'd0);
    chk("rst_ready_b", 32'(tx_ready_b), 32'd0);
    chk("rst_rxd_b", 32'(rx_data_b), 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    tick;
    chk("post_rst_ready_a", 32'(tx_ready_a), 32'd1);

    // 3-word TX burst on A
    tx_valid_a = 1'b1; tx_data_a = 16'h1234; exp_tx_a.push_back(16'h1234);
    tick;
    chk("burst_state_tx", 32'(state_a), 32'd1);
    chk("burst_oe_c1", 32'(dut_a.oe), 32'd1);
    tx_data_a = 16'hABCD; exp_tx_a.push_back(16'hABCD);
    tick;
    tx_data_a = 16'h0F0F; exp_tx_a.push_back(16'h0F0F);
    tick;
    chk("burst_oe_c3", 32'(dut_a.oe), 32'd1);
    tx_valid_a = 1'b0;
    tick;
    chk("burst_turn1", 32'(state_a), 32'd2);
    chk("burst_oe_off", 32'(dut_a.oe), 32'd0);
    tick;
    chk("burst_turn2", 32'(state_a), 32'd2);
    chk("turn_ready", 32'(tx_ready_a), 32'd0);
    tick;
    chk("burst_idle", 32'(state_a), 32'd0);

    // 4-word RX on A, two-cycle latency
    rx_req_a = 1'b1;
    tick;
    chk("rx_state", 32'(state_a), 32'd3);
    chk("rx_ready", 32'(tx_ready_a), 32'd0);
    en_a = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drv_a = 16'(i);
      exp_rx_a.push_back(16'(i));
      if (i == 4) rx_req_a = 1'b0;
      tick;
      if (i == 1) chk("rx_lat_early", 32'(rx_valid_a), 32'd0);
      if (i == 2) begin
        chk("rx_lat_on", 32'(rx_valid_a), 32'd1);
        chk("rx_first_word", 32'(rx_data_a), 32'h0001);
      end
    end
    chk("rx_turn", 32'(state_a), 32'd2);
    en_a = 1'b0;
    repeat (2) tick;
    chk("rx_idle", 32'(state_a), 32'd0);
    chk("rx_hold", 32'(rx_data_a), 32'h0004);
    tick;

    // simultaneous requests on A: TX wins, RX follows after TURN and IDLE
    tx_valid_a = 1'b1; tx_data_a = 16'h5555; exp_tx_a.push_back(16'h5555);
    rx_req_a = 1'b1;
    @(negedge clk);
    chk("prio_tx_ready", 32'(tx_ready_a), 32'd1);
    tick;
    chk("prio_tx_state", 32'(state_a), 32'd1);
    tx_valid_a = 1'b0;
    tick;
    chk("prio_turn", 32'(state_a), 32'd2);
    repeat (2) tick;
    chk("prio_idle", 32'(state_a), 32'd0);
    en_a = 1'b1; drv_a = 16'h7777; exp_rx_a.push_back(16'h7777);
    tick;
    chk("prio_rx_state", 32'(state_a), 32'd3);
    rx_req_a = 1'b0;
    tick;
    en_a = 1'b0;
    repeat (4) tick;

    // B: RX priority, no resync stage, five-cycle turnaround
    tx_valid_b = 1'b1; tx_data_b = 8'hA5; exp_tx_b.push_back(8'hA5);
    rx_req_b = 1'b1; en_b = 1'b1; drv_b = 8'h3C; exp_rx_b.push_back(8'h3C);
    @(negedge clk);
    chk("b_prio_ready", 32'(tx_ready_b), 32'd0);
    tick;
    chk("b_rx_state", 32'(state_b), 32'd3);
    chk("b_lat_early", 32'(rx_valid_b), 32'd0);
    rx_req_b = 1'b0;
    tick;
    chk("b_lat_on", 32'(rx_valid_b), 32'd1);
    chk("b_rx_word", 32'(rx_data_b), 32'h3C);
    chk("b_turn", 32'(state_b), 32'd2);
    en_b = 1'b0;
    repeat (4) tick;
    chk("b_turn_c5", 32'(state_b), 32'd2);
    tick;
    chk("b_idle", 32'(state_b), 32'd0);
    tick;
    chk("b_tx_state", 32'(state_b), 32'd1);
    chk("b_oe_on", 32'(dut_b.oe), 32'd1);
    tx_valid_b = 1'b0;
    repeat (8) tick;
    chk("b_final_idle", 32'(state_b), 32'd0);

    // OE18 tie passes straight through
    oe18_tie = 1'b1;
    #1;
    chk("oe18_b0_hi", 32'(dut_b.g_pad[0].u_pad.OE18), 32'd1);
    chk("oe18_b7_hi", 32'(dut_b.g_pad[7].u_pad.OE18), 32'd1);
    chk("oe18_a15_hi", 32'(dut_a.g_pad[15].u_pad.OE18), 32'd1);
    oe18_tie = 1'b0;
    #1;
    chk("oe18_b7_lo", 32'(dut_b.g_pad[7].u_pad.OE18), 32'd0);
    tick;

    // reset in the middle of a TX burst on A
    tx_valid_a = 1'b1; tx_data_a = 16'hBEEF; exp_tx_a.push_back(16'hBEEF);
    tick;
    tx_data_a = 16'hCAFE;
    tick;
    #2;
    rst_n = 1'b0;
    tx_valid_a = 1'b0;
    #1;
    chk("async_oe_drop", 32'(dut_a.oe), 32'd0);
    chk("async_state", 32'(state_a), 32'd0);
    chk("async_ready", 32'(tx_ready_a), 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    tick;
    chk("rel_state", 32'(state_a), 32'd0);
    chk("rel_rxv", 32'(rx_valid_a), 32'd0);
    chk("rel_ready", 32'(tx_ready_a), 32'd1);
    repeat (2) tick;

    chk("sb_tx_a_empty", 32'(exp_tx_a.size()), 32'd0);
    chk("sb_rx_a_empty", 32'(exp_rx_a.size()), 32'd0);
    chk("sb_tx_b_empty", 32'(exp_tx_b.size()), 32'd0);
    chk("sb_rx_b_empty", 32'(exp_rx_b.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
